cache_refill_ctrl: RTL and testbench

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_refill_ctrl.sv | 158 +++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Cache refill / write-through controller. Refills a line critical-word-first
// with one idle cycle between memory beats, or forwards a single word write.
module cache_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [31:0]                   cpu_wdata,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_ack,
  input  logic [31:0]                   mem_rdata,
  output logic                          fill_we,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word,
  output logic [31:0]                   fill_data
);

  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int BEAT_W = IDX_W + 1;
  localparam int OFF_W  = IDX_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_FILL, S_GAP, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-OFF_W-1:0] line_q, line_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic                    fill_we_q, fill_we_d;
  logic [IDX_W-1:0]        fill_word_q, fill_word_d;
  logic [31:0]             fill_data_q, fill_data_d;

  // Byte-lane bits never reach memory; addresses are word aligned.
  logic unused_lsb;
  assign unused_lsb = ^cpu_addr[1:0];

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_we_d   = 1'b0;
    fill_word_d = fill_word_q;
    fill_data_d = fill_data_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          line_d      = cpu_addr[ADDR_W-1:OFF_W];
          idx_d       = cpu_addr[OFF_W-1:2];
          beat_d      = '0;
          busy_d      = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we;
          // The critical word is also the aligned write address.
          mem_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = cpu_wdata;
          state_d     = cpu_we ? S_WRITE : S_FILL;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          fill_we_d   = 1'b1;
          fill_word_d = idx_q;
          fill_data_d = mem_rdata;
          idx_d       = idx_q + 1'b1;
          beat_d      = beat_q + 1'b1;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (beat_q == BEAT_W'(LINE_WORDS)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = {line_q, idx_q, 2'b00};
          state_d    = S_FILL;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      idx_q       <= '0;
      beat_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_we_q   <= 1'b0;
      fill_word_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fill_we_q   <= fill_we_d;
      fill_word_q <= fill_word_d;
      fill_data_q <= fill_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign fill_we   = fill_we_q;
  assign fill_word = fill_word_q;
  assign fill_data = fill_data_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl: latency-configurable memory model,
// per-cycle protocol monitor and a line-level expected-sequence model.
module tb_cache_refill_ctrl;
  localparam int LW = 4;
  localparam int AW = 32;

  logic          clk, reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          busy, done, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          fill_we;
  logic [1:0]    fill_word;
  logic [31:0]   fill_data;

  cache_refill_ctrl #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_word(fill_word), .fill_data(fill_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] salt = 32'h1234_5678;
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Memory: acks after `lat` waiting cycles, or every cycle when tie_ack is set.
  int lat = 0;
  int lat_cnt = 0;
  bit tie_ack = 0;
  bit stray = 0;
  always @(negedge clk) begin
    if (tie_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = rd_fn(mem_addr);
    end else if (mem_req) begin
      if (lat_cnt >= lat) begin
        mem_ack = 1'b1;
        lat_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        lat_cnt++;
      end
      mem_rdata = rd_fn(mem_addr);
    end else begin
      mem_ack   = stray;
      lat_cnt   = 0;
      mem_rdata = $urandom;
    end
  end

  // Monitor: records handshakes and fill strobes, checks cycle-level protocol.
  logic [31:0] hs_addr[$];
  bit          hs_we[$];
  logic [31:0] hs_wd[$];
  int          hs_cyc[$];
  int          fl_word[$];
  logic [31:0] fl_data[$];
  int          done_cnt = 0;
  int          cyc = 0;
  bit          p_hs = 0, p_hs_fill = 0, p_pend = 0, p_we = 0;
  logic [31:0] p_addr = '0, p_wd = '0;

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (!reset) begin
      p_hs = 0; p_hs_fill = 0; p_pend = 0;
    end else begin
      if (p_pend) begin
        chk("req_hold", 64'(mem_req), 64'd1);
        chk("addr_hold", 64'(mem_addr), 64'(p_addr));
        chk("wdata_hold", 64'(mem_wdata), 64'(p_wd));
        chk("we_hold", 64'(mem_we), 64'(p_we));
      end
      if (p_hs) chk("gap", 64'(mem_req), 64'd0);
      chk("fill_strobe", 64'(fill_we), 64'(p_hs_fill));
      if (fill_we) begin
        fl_word.push_back(int'(fill_word));
        fl_data.push_back(fill_data);
      end
      if (done) done_cnt++;
      p_hs      = mem_req && mem_ack;
      p_hs_fill = p_hs && !mem_we;
      p_pend    = mem_req && !mem_ack;
      p_addr    = mem_addr;
      p_wd      = mem_wdata;
      p_we      = mem_we;
      if (p_hs) begin
        hs_addr.push_back(mem_addr);
        hs_we.push_back(mem_we);
        hs_wd.push_back(mem_wdata);
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_log();
    hs_addr.delete(); hs_we.delete(); hs_wd.delete(); hs_cyc.delete();
    fl_word.delete(); fl_data.delete();
    done_cnt = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_fill_we"}, 64'(fill_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_fill_word"}, 64'(fill_word), 64'd0);
    chk({tag, "_fill_data"}, 64'(fill_data), 64'd0);
  endtask

  task automatic send_req(input bit we, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk); #2;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    @(negedge clk); #2;
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
    chk("busy_on", 64'(busy), 64'd1);
  endtask

  task automatic run_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input int l, input bit glitch, input bit spacing);
    bit seen;
    logic [31:0] base, ea;
    int idx;
    lat  = l;
    salt = $urandom;
    clear_log();
    send_req(we, a, wd);
    if (glitch) begin
      @(negedge clk); #2;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      @(negedge clk); #2;
      cpu_req = 1'b0;
    end
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (done) begin seen = 1; break; end
      @(negedge clk); #2;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd1);
    @(negedge clk); #2;
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_off", 64'(busy), 64'd0);
    chk("done_cnt", 64'(done_cnt), 64'd1);
    if (we) begin
      chk("hs_n", 64'(hs_addr.size()), 64'd1);
      if (hs_addr.size() > 0) begin
        chk("wr_addr", 64'(hs_addr[0]), 64'(a & 32'hFFFF_FFFC));
        chk("wr_dir", 64'(hs_we[0]), 64'd1);
        chk("wr_data", 64'(hs_wd[0]), 64'(wd));
      end
      chk("wr_fill_n", 64'(fl_word.size()), 64'd0);
    end else begin
      chk("hs_n", 64'(hs_addr.size()), 64'(LW));
      chk("fill_n", 64'(fl_word.size()), 64'(LW));
      base = a & ~(32'(LW * 4) - 32'd1);
      for (int k = 0; k < LW; k++) begin
        idx = ((int'(a) >>> 2) + k) % LW;
        if (idx < 0) idx += LW;
        ea  = base + 32'(idx * 4);
        if (k < hs_addr.size()) begin
          chk("fill_addr", 64'(hs_addr[k]), 64'(ea));
          chk("fill_dir", 64'(hs_we[k]), 64'd0);
        end
        if (k < fl_word.size()) begin
          chk("fill_word", 64'(fl_word[k]), 64'(idx));
          chk("fill_data", 64'(fl_data[k]), 64'(rd_fn(ea)));
        end
        if (spacing && k > 0 && k < hs_cyc.size())
          chk("beat_gap", 64'(hs_cyc[k] - hs_cyc[k-1]), 64'd2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 chk_all_zero("rst");
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;

    // Directed cases from the line-level requirements.
    run_txn(1'b0, 32'h0000_0104, 32'h0, 2, 1'b0, 1'b0);
    run_txn(1'b1, 32'h0000_0203, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);
    tie_ack = 1;
    run_txn(1'b0, 32'h0000_0000, 32'h0, 0, 1'b0, 1'b1);
    run_txn(1'b1, 32'h0000_0ABC, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
    tie_ack = 0;
    run_txn(1'b0, 32'h0000_0100, 32'h0, 1, 1'b1, 1'b0);

    // Stray acks while idle.
    clear_log();
    stray = 1;
    repeat (6) begin
      @(negedge clk); #2;
      chk("stray_busy", 64'(busy), 64'd0);
    end
    stray = 0;
    chk("stray_fill", 64'(fl_word.size()), 64'd0);
    chk("stray_done", 64'(done_cnt), 64'd0);

    // Asynchronous reset in the middle of a refill.
    lat  = 1;
    salt = $urandom;
    clear_log();
    send_req(1'b0, $urandom, 32'h0);
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (fl_word.size() >= 2) begin seen = 1; break; end
      @(negedge clk); #2;
    end
    chk("two_beats", 64'(seen), 64'd1);
    @(negedge clk); #3;
    reset = 1'b0;
    #1 chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;
    clear_log();
    repeat (5) @(negedge clk);
    #2;
    chk("post_rst_fill", 64'(fl_word.size()), 64'd0);
    chk("post_rst_done", 64'(done_cnt), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    run_txn(1'b0, $urandom, 32'h0, 1, 1'b0, 1'b0);

    // Randomized mix.
    for (int t = 0; t < 20; t++)
      run_txn($urandom_range(0, 2) == 0, $urandom, $urandom, $urandom_range(0, 3), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
